card_deal_ctrl: RTL and testbench

- Game sequencer for the two-player card game.
- Owns the turn state, arbitrates the shared random-card source between the two players, maps random words to cards, and keeps per-player hand counts and scores.
- Sits between the keypad decoder and the display/score logic, and drives the advance request of the 5-bit LFSR.

---
 rtl/card_game_pkg.sv | 34 +++
 rtl/card_map.sv | 16 +
 rtl/card_deal_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_card_deal_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_game_pkg.sv
// Shared types and constants for the two-player card game: FSM states, key codes,
// winner encodings and field widths, plus the end-of-game score comparison.
package card_game_pkg;

  typedef enum logic [1:0] {
    P1_WAIT = 2'd0,
    P2_WAIT = 2'd1,
    DRAW    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] KEY_DRAW_C  = 4'b0010;
  localparam logic [3:0] KEY_PASS1_C = 4'b0011;
  localparam logic [3:0] KEY_PASS2_C = 4'b0001;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int COLOR_W  = 2;
  localparam int NUMBER_W = 3;
  localparam int HAND_W   = 3;
  localparam int SCORE_W  = 6;
  localparam int TURN_W   = 8;

  function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] s1,
                                          input logic [SCORE_W-1:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_TIE;
  endfunction

endpackage

// File: rtl/card_map.sv
// Combinational mapping of a 5-bit random word to a card: color 1..3, number 0..4.
module card_map
  import card_game_pkg::*;
(
  input  logic [4:0]          rnd,
  output logic [COLOR_W-1:0]  color,
  output logic [NUMBER_W-1:0] number
);

  // Small-range modulo done by a single conditional subtract.
  always_comb begin
    color  = (rnd[4:3] == 2'd3) ? 2'd1 : rnd[4:3] + 2'd1;
    number = (rnd[2:0] >= 3'd5) ? rnd[2:0] - 3'd5 : rnd[2:0];
  end

endmodule

// File: rtl/card_deal_ctrl.sv
// Two-player card game sequencer: turns, LFSR advance requests, card dealing, hands and scores.
// Optional macro CARD_DEAL_AUTO_PASS_EN: a draw that fills the drawer's hand also passes the turn.
module card_deal_ctrl
  import card_game_pkg::*;
#(
  parameter int         HAND_MAX  = 5,
  parameter int         MAX_TURNS = 16,
  parameter logic [3:0] KEY_DRAW  = KEY_DRAW_C,
  parameter logic [3:0] KEY_PASS1 = KEY_PASS1_C,
  parameter logic [3:0] KEY_PASS2 = KEY_PASS2_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypad_in,
  input  logic       key_valid,
  input  logic [4:0] rnd,
  output logic       rnd_en,
  output logic       card_valid,
  output logic       card_player,
  output logic [1:0] card_color,
  output logic [2:0] card_number,
  output logic       whose,
  output logic [7:0] turn_cnt,
  output logic [2:0] hand_cnt1,
  output logic [2:0] hand_cnt2,
  output logic [5:0] score1,
  output logic [5:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [HAND_W-1:0] HAND_FULL = HAND_W'(HAND_MAX);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(MAX_TURNS);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic                whose_q, whose_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [HAND_W-1:0]   hand1_q, hand1_d, hand2_q, hand2_d;
  logic [SCORE_W-1:0]  score1_q, score1_d, score2_q, score2_d;
  logic                card_valid_q, card_valid_d;
  logic                card_player_q, card_player_d;
  logic [COLOR_W-1:0]  card_color_q, card_color_d;
  logic [NUMBER_W-1:0] card_number_q, card_number_d;
  logic                rnd_en_q, rnd_en_d;
  logic                game_over_q, game_over_d;
  logic [1:0]          winner_q, winner_d;

  logic [COLOR_W-1:0]  map_color;
  logic [NUMBER_W-1:0] map_number;
  logic [HAND_W-1:0]   cur_hand;
  logic [HAND_W-1:0]   new_hand;
  logic [TURN_W-1:0]   turn_inc;
  logic                do_pass;
  logic                go_done;

  card_map u_map (
    .rnd    (rnd),
    .color  (map_color),
    .number (map_number)
  );

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    whose_d       = whose_q;
    turn_d        = turn_q;
    hand1_d       = hand1_q;
    hand2_d       = hand2_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    card_valid_d  = 1'b0;
    card_player_d = card_player_q;
    card_color_d  = card_color_q;
    card_number_d = card_number_q;
    rnd_en_d      = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    do_pass       = 1'b0;
    go_done       = 1'b0;
    cur_hand      = whose_q ? hand2_q : hand1_q;
    new_hand      = cur_hand;
    turn_inc      = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;

    case (state_q)
      P1_WAIT, P2_WAIT: begin
        if (key_valid && keypad_in == KEY_DRAW && cur_hand < HAND_FULL) begin
          state_d  = DRAW;
          ret_d    = state_q;
          rnd_en_d = 1'b1;
        end else if (key_valid &&
                     keypad_in == ((state_q == P1_WAIT) ? KEY_PASS1 : KEY_PASS2)) begin
          do_pass = 1'b1;
        end
      end
      // rnd is sampled at the edge that closes DRAW; the card lands with the counters.
      DRAW: begin
        card_valid_d  = 1'b1;
        card_player_d = whose_q;
        card_color_d  = map_color;
        card_number_d = map_number;
        if (!whose_q) begin
          hand1_d  = hand1_q + 3'd1;
          score1_d = score1_q + {3'b000, map_number};
          new_hand = hand1_d;
        end else begin
          hand2_d  = hand2_q + 3'd1;
          score2_d = score2_q + {3'b000, map_number};
          new_hand = hand2_d;
        end
        state_d = ret_q;
        if (hand1_d == HAND_FULL && hand2_d == HAND_FULL) begin
          go_done = 1'b1;
        end
`ifdef CARD_DEAL_AUTO_PASS_EN
        else if (new_hand == HAND_FULL) begin
          do_pass = 1'b1;
        end
`endif
      end
      DONE: begin
      end
      default: begin
      end
    endcase

    if (do_pass) begin
      whose_d = ~whose_q;
      turn_d  = turn_inc;
      if (turn_inc == TURN_LAST) go_done = 1'b1;
      else                       state_d = whose_q ? P1_WAIT : P2_WAIT;
    end

    if (go_done) begin
      state_d     = DONE;
      game_over_d = 1'b1;
      winner_d    = win_code(score1_d, score2_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= P1_WAIT;
      ret_q         <= P1_WAIT;
      whose_q       <= 1'b0;
      turn_q        <= '0;
      hand1_q       <= '0;
      hand2_q       <= '0;
      score1_q      <= '0;
      score2_q      <= '0;
      card_valid_q  <= 1'b0;
      card_player_q <= 1'b0;
      card_color_q  <= '0;
      card_number_q <= '0;
      rnd_en_q      <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= WIN_NONE;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      whose_q       <= whose_d;
      turn_q        <= turn_d;
      hand1_q       <= hand1_d;
      hand2_q       <= hand2_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      card_valid_q  <= card_valid_d;
      card_player_q <= card_player_d;
      card_color_q  <= card_color_d;
      card_number_q <= card_number_d;
      rnd_en_q      <= rnd_en_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign rnd_en      = rnd_en_q;
  assign card_valid  = card_valid_q;
  assign card_player = card_player_q;
  assign card_color  = card_color_q;
  assign card_number = card_number_q;
  assign whose       = whose_q;
  assign turn_cnt    = turn_q;
  assign hand_cnt1   = hand1_q;
  assign hand_cnt2   = hand2_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Scoreboard bench for card_deal_ctrl: stimulus queues expected cards, a monitor checks each deal.
module tb_card_deal_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keypad_in = 4'd0;
  logic       key_valid = 1'b0;
  logic [4:0] rnd = 5'd0;
  logic       rnd_en, card_valid, card_player, whose, game_over;
  logic [1:0] card_color, winner;
  logic [2:0] card_number, hand_cnt1, hand_cnt2;
  logic [7:0] turn_cnt;
  logic [5:0] score1, score2;

  int total = 0;
  int bad = 0;
  int rnd_en_n = 0;
  int card_n = 0;
  logic [5:0] exp_q[$];

  localparam logic [3:0] K_DRAW = 4'b0010;
  localparam logic [3:0] K_P1   = 4'b0011;
  localparam logic [3:0] K_P2   = 4'b0001;

  card_deal_ctrl dut (
    .clk(clk), .rst(rst), .keypad_in(keypad_in), .key_valid(key_valid), .rnd(rnd),
    .rnd_en(rnd_en), .card_valid(card_valid), .card_player(card_player),
    .card_color(card_color), .card_number(card_number), .whose(whose),
    .turn_cnt(turn_cnt), .hand_cnt1(hand_cnt1), .hand_cnt2(hand_cnt2),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every card the DUT presents must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rnd_en) rnd_en_n++;
    if (card_valid) begin
      card_n++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL card_unexpected: got %0h, expected no card", {card_player, card_color, card_number});
      end else begin
        check("card", int'({card_player, card_color, card_number}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(logic [3:0] k);
    @(posedge clk); #1;
    keypad_in = k; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; keypad_in = 4'd0;
  endtask

  task automatic draw(logic [4:0] r, logic p, logic [1:0] c, logic [2:0] n, logic expect_card);
    rnd = r;
    if (expect_card) exp_q.push_back({p, c, n});
    press(K_DRAW);
    idle(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    rnd_en_n = 0;
    card_n = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rnd = 5'b11100;
    idle(2);
    check("rst_whose", whose, 0);
    check("rst_turn", turn_cnt, 0);
    check("rst_hand1", hand_cnt1, 0);
    check("rst_score1", score1, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_card_valid", card_valid, 0);
    check("rst_rnd_en", rnd_en, 0);
    rst = 1'b0;
    idle(1);

    // First deal: exact latency and card mapping
    exp_q.push_back({1'b0, 2'd1, 3'd4});
    press(K_DRAW);
    check("lat_rnd_en_k1", rnd_en, 1);
    check("lat_card_k1", card_valid, 0);
    idle(1);
    check("lat_card_k2", card_valid, 1);
    check("lat_rnd_en_k2", rnd_en, 0);
    check("first_hand1", hand_cnt1, 1);
    check("first_score1", score1, 4);
    idle(1);
    check("lat_card_k3", card_valid, 0);
    check("card_color_hold", card_color, 1);
    check("card_number_hold", card_number, 4);

    // Wrong pass key ignored, right one passes
    press(K_P2);
    idle(1);
    check("wrong_pass_whose", whose, 0);
    check("wrong_pass_turn", turn_cnt, 0);
    press(K_P1);
    idle(1);
    check("pass_whose", whose, 1);
    check("pass_turn", turn_cnt, 1);

    // Full hand: six draws, five cards
    do_reset();
    draw(5'b00000, 1'b0, 2'd1, 3'd0, 1'b1);
    draw(5'b01001, 1'b0, 2'd2, 3'd1, 1'b1);
    draw(5'b10010, 1'b0, 2'd3, 3'd2, 1'b1);
    draw(5'b11011, 1'b0, 2'd1, 3'd3, 1'b1);
    draw(5'b00101, 1'b0, 2'd1, 3'd0, 1'b1);
    draw(5'b00110, 1'b0, 2'd1, 3'd1, 1'b0);
    idle(2);
    check("full_hand1", hand_cnt1, 5);
    check("full_score1", score1, 6);
    check("full_rnd_en_pulses", rnd_en_n, 5);
    check("full_card_pulses", card_n, 5);
    check("full_not_done", game_over, 0);

    // Both hands full: 12 vs 9, P1 wins
    do_reset();
    draw(5'b00100, 1'b0, 2'd1, 3'd4, 1'b1);
    draw(5'b01100, 1'b0, 2'd2, 3'd4, 1'b1);
    draw(5'b10100, 1'b0, 2'd3, 3'd4, 1'b1);
    draw(5'b11000, 1'b0, 2'd1, 3'd0, 1'b1);
    draw(5'b00101, 1'b0, 2'd1, 3'd0, 1'b1);
    press(K_P1);
    idle(1);
    draw(5'b00100, 1'b1, 2'd1, 3'd4, 1'b1);
    draw(5'b10100, 1'b1, 2'd3, 3'd4, 1'b1);
    draw(5'b00110, 1'b1, 2'd1, 3'd1, 1'b1);
    check("pre_done_game_over", game_over, 0);
    check("pre_done_winner", winner, 0);
    draw(5'b01101, 1'b1, 2'd2, 3'd0, 1'b1);
    draw(5'b10000, 1'b1, 2'd3, 3'd0, 1'b1);
    check("game_score1", score1, 12);
    check("game_score2", score2, 9);
    check("game_hand2", hand_cnt2, 5);
    check("game_over", game_over, 1);
    check("game_winner", winner, 1);
    press(K_DRAW);
    press(K_P2);
    press(K_P1);
    idle(3);
    check("done_sticky_turn", turn_cnt, 1);
    check("done_sticky_whose", whose, 1);
    check("done_sticky_over", game_over, 1);
    check("done_sticky_winner", winner, 1);

    // Async reset in the DRAW cycle discards the card
    do_reset();
    press(K_P1);
    idle(1);
    press(K_DRAW);
    check("abort_in_draw", rnd_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_card_valid", card_valid, 0);
    check("abort_rnd_en", rnd_en, 0);
    check("abort_whose", whose, 0);
    check("abort_turn", turn_cnt, 0);
    check("abort_hand2", hand_cnt2, 0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("abort_after_hand2", hand_cnt2, 0);
    check("abort_after_score2", score2, 0);
    check("abort_after_cards", card_n, 0);

    // MAX_TURNS passes end the game in a tie
    do_reset();
    for (int i = 0; i < 15; i++) begin
      press((i % 2 == 0) ? K_P1 : K_P2);
    end
    idle(1);
    check("turns15_turn", turn_cnt, 15);
    check("turns15_over", game_over, 0);
    press(K_P2);
    idle(1);
    check("turns16_turn", turn_cnt, 16);
    check("turns16_whose", whose, 0);
    check("turns16_over", game_over, 1);
    check("turns16_winner", winner, 3);
    press(K_P1);
    idle(1);
    check("turns_sticky", turn_cnt, 16);

    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
